// File: rtl/ps2_frame_rx.sv
// PS/2 keyboard frame receiver: synchronizes and debounces the raw lines,
// then decodes 11-bit frames into a two-byte keycode history.
module ps2_frame_rx #(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int TIMEOUT_CYCLES  = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] keycode,
    output logic        oflag,
    output logic        parity_err,
    output logic        frame_err
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY,
        STOP
    } state_t;

    // index 0 = ps2_clk, index 1 = ps2_data
    logic [1:0]    s1_q, s2_q;
    logic [1:0]    filt_q, filt_d;
    logic [DW-1:0] dcnt_q [2];
    logic [DW-1:0] dcnt_d [2];
    logic          fclk_prev_q;

    state_t        state_q, state_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] idle_q, idle_d;
    logic [15:0]   kc_q, kc_d;
    logic          oflag_q, oflag_d;
    logic          perr_q, perr_d;
    logic          ferr_q, ferr_d;

    logic          fall;
    logic          din;
    logic          timeout;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            filt_d[i] = filt_q[i];
            dcnt_d[i] = '0;
            if (s2_q[i] != filt_q[i]) begin
                if (dcnt_q[i] == DB_LAST) begin
                    filt_d[i] = s2_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign fall    = fclk_prev_q & ~filt_q[0];
    assign din     = filt_q[1];
    // A falling edge in the same cycle as the limit keeps the frame alive
    assign timeout = (state_q != IDLE) && !fall && (idle_q >= TO_LAST);

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        idle_d  = idle_q;
        kc_d    = kc_q;
        oflag_d = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;

        if (state_q == IDLE || fall) begin
            idle_d = '0;
        end else if (idle_q != TO_MAX) begin
            idle_d = idle_q + 1'b1;
        end

        if (timeout) begin
            ferr_d  = 1'b1;
            state_d = IDLE;
            bit_d   = '0;
            idle_d  = '0;
        end else if (fall) begin
            unique case (state_q)
                IDLE: begin
                    if (!din) begin
                        state_d = SHIFT;
                        bit_d   = '0;
                    end
                end
                SHIFT: begin
                    shift_d = {din, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    par_d   = din;
                    state_d = STOP;
                end
                STOP: begin
                    if (^{shift_q, par_q} != 1'b1) begin
                        perr_d = 1'b1;
                    end else if (!din) begin
                        ferr_d = 1'b1;
                    end else begin
                        kc_d    = {kc_q[7:0], shift_q};
                        oflag_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q        <= 2'b11;
            s2_q        <= 2'b11;
            filt_q      <= 2'b11;
            dcnt_q[0]   <= '0;
            dcnt_q[1]   <= '0;
            fclk_prev_q <= 1'b1;
            state_q     <= IDLE;
            bit_q       <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            idle_q      <= '0;
            kc_q        <= '0;
            oflag_q     <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            s1_q        <= {ps2_data, ps2_clk};
            s2_q        <= s1_q;
            filt_q      <= filt_d;
            dcnt_q[0]   <= dcnt_d[0];
            dcnt_q[1]   <= dcnt_d[1];
            fclk_prev_q <= filt_q[0];
            state_q     <= state_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            idle_q      <= idle_d;
            kc_q        <= kc_d;
            oflag_q     <= oflag_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
        end
    end

    assign keycode    = kc_q;
    assign oflag      = oflag_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed and randomized frame checks for ps2_frame_rx against a
// frame-level reference model of the keycode history and error pulses.
module tb_ps2_frame_rx;

    localparam int DEB    = 4;
    localparam int TMO    = 2000;
    localparam int LAT    = 2 + DEB + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        ps2_clk;
    logic        ps2_data;
    logic [15:0] keycode;
    logic        oflag;
    logic        parity_err;
    logic        frame_err;

    ps2_frame_rx #(
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .keycode   (keycode),
        .oflag     (oflag),
        .parity_err(parity_err),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          n_o = 0, n_pe = 0, n_fe = 0;
    int          o_cyc = 0;
    int          viol = 0;
    int          fall_cyc = 0;
    int          compared = 0;
    int          mismatched = 0;
    logic        prev_pulse = 1'b0;
    logic [15:0] prev_kc = 16'h0;
    logic [15:0] m_kc;

    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder: pulse counts, exclusivity, spacing and keycode hold
    always @(negedge clk) begin
        int s;
        if (rst) begin
            prev_pulse = 1'b0;
            prev_kc    = keycode;
        end else begin
            s = int'(oflag) + int'(parity_err) + int'(frame_err);
            if (s > 1) viol++;
            if (s > 0 && prev_pulse) viol++;
            if (keycode !== prev_kc && !oflag) viol++;
            if (oflag) begin
                n_o++;
                o_cyc = cyc;
            end
            if (parity_err) n_pe++;
            if (frame_err) n_fe++;
            prev_pulse = (s > 0);
            prev_kc    = keycode;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive bits[0..n-1]; each bit period is 100 clk with data set
    // while the clock is high. glitch_at places a 2-cycle clock glitch.
    task automatic send_bits(input logic [10:0] bits, input int n,
                             input int glitch_at);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            if (i == glitch_at) begin
                idle_cycles(10);
                ps2_clk = 1'b0;
                idle_cycles(2);
                ps2_clk = 1'b1;
                idle_cycles(13);
            end else begin
                idle_cycles(25);
            end
            ps2_clk = 1'b0;
            if (i == 10) fall_cyc = cyc;
            idle_cycles(50);
            ps2_clk = 1'b1;
            idle_cycles(25);
        end
        ps2_data = 1'b1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d,
                                             input logic bad_par,
                                             input logic stop);
        logic p;
        p = ~(^d) ^ bad_par;
        return {stop, p, d, 1'b0};
    endfunction

    task automatic do_frame(input string tag, input logic [7:0] d,
                            input logic bad_par, input logic stop,
                            input int glitch_at);
        int o0, pe0, fe0;
        int eo, epe, efe;
        o0  = n_o;
        pe0 = n_pe;
        fe0 = n_fe;
        eo  = 0;
        epe = 0;
        efe = 0;
        if (bad_par) begin
            epe = 1;
        end else if (!stop) begin
            efe = 1;
        end else begin
            eo   = 1;
            m_kc = {m_kc[7:0], d};
        end
        send_bits(mk_frame(d, bad_par, stop), 11, glitch_at);
        idle_cycles(10);
        chk({tag, ".oflag"}, n_o - o0, eo);
        chk({tag, ".perr"}, n_pe - pe0, epe);
        chk({tag, ".ferr"}, n_fe - fe0, efe);
        chk({tag, ".keycode"}, {16'h0, keycode}, {16'h0, m_kc});
        if (eo == 1) begin
            chk({tag, ".latency"}, o_cyc - fall_cyc, LAT);
        end
    endtask

    initial begin
        int fe0;
        logic [7:0] d;
        int mode;
        rst      = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        m_kc     = 16'h0;
        idle_cycles(5);
        chk("reset.keycode", {16'h0, keycode}, 32'h0);
        chk("reset.pulses", {oflag, parity_err, frame_err}, 3'b000);
        rst = 1'b0;
        idle_cycles(20);
        chk("idle.nopulse", n_o + n_pe + n_fe, 0);

        do_frame("f29", 8'h29, 1'b0, 1'b1, -1);
        do_frame("fF0", 8'hF0, 1'b0, 1'b1, -1);
        do_frame("f29b", 8'h29, 1'b0, 1'b1, -1);
        chk("makebreak", {16'h0, keycode}, 32'h0000F029);
        do_frame("f1C_par", 8'h1C, 1'b1, 1'b1, -1);
        do_frame("f23_stop", 8'h23, 1'b0, 1'b0, -1);
        do_frame("f4D", 8'h4D, 1'b0, 1'b1, -1);

        // Truncated frame: start plus 4 data bits, then silence
        fe0 = n_fe;
        send_bits(mk_frame(8'h5A, 1'b0, 1'b1), 5, -1);
        idle_cycles(TMO + 100);
        chk("timeout.ferr", n_fe - fe0, 1);
        chk("timeout.keycode", {16'h0, keycode}, {16'h0, m_kc});
        do_frame("f23_after_to", 8'h23, 1'b0, 1'b1, -1);

        do_frame("glitch", 8'hA5, 1'b0, 1'b1, 4);

        // Reset in the middle of a frame
        send_bits(mk_frame(8'h77, 1'b0, 1'b1), 4, -1);
        ps2_clk = 1'b0;
        idle_cycles(10);
        rst = 1'b1;
        #1;
        chk("midrst.keycode", {16'h0, keycode}, 32'h0);
        chk("midrst.pulses", {oflag, parity_err, frame_err}, 3'b000);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        m_kc     = 16'h0;
        idle_cycles(5);
        rst = 1'b0;
        idle_cycles(20);
        do_frame("post_rst29", 8'h29, 1'b0, 1'b1, -1);

        for (int k = 0; k < 16; k++) begin
            d    = 8'($urandom);
            mode = int'($urandom_range(0, 5));
            do_frame("rand", d, mode == 0, mode != 1,
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : -1);
        end

        chk("protocol.viol", viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ps2_frame_rx.md
PS2_FRAME_RX -- requirements
Module: ps2_frame_rx

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, 20: consecutive clk cycles a synchronized PS/2 line must hold a new level before the filtered value follows it.
REQ-002 Parameter TIMEOUT_CYCLES, 50000: clk cycles without a filtered ps2_clk falling edge that abort a frame in progress.
REQ-003 Port clk, input, 1: single system clock; all logic in this domain.
REQ-004 Port rst, input, 1: reset, asynchronous, active-high.
REQ-005 Port ps2_clk, input, 1: raw PS/2 clock from the keyboard, asynchronous, idle high.
REQ-006 Port ps2_data, input, 1: raw PS/2 data from the keyboard, asynchronous, idle high.
REQ-007 Port keycode, output, 16: {previous byte, latest byte}, for make/break (F0) and extended (E0) decoding downstream.
REQ-008 Port oflag, output, 1: one-cycle pulse when keycode has just been updated with a valid byte.
REQ-009 Port parity_err, output, 1: one-cycle pulse when a frame is rejected for bad odd parity.
REQ-010 Port frame_err, output, 1: one-cycle pulse when a frame is rejected for bad stop bit or timeout.

Function
REQ-011 Both raw lines SHALL pass through a 2-flop synchronizer, then a debounce filter per REQ-001; a level held for fewer than DEBOUNCE_CYCLES cycles SHALL leave the filtered value unchanged.
REQ-012 A falling edge SHALL be detected when the filtered ps2_clk is 1 in the previous cycle and 0 in the current cycle; filtered ps2_data SHALL be sampled only in that cycle.
REQ-013 FSM states IDLE, SHIFT, PARITY, STOP; all transitions SHALL occur only on a detected falling edge or on timeout.
REQ-014 IDLE: sampled 0 (start bit) -> SHIFT with bit counter 0; sampled 1 -> remain IDLE, with no error pulse.
REQ-015 SHIFT: shift the data bit in LSB first; after the 8th bit -> PARITY.
REQ-016 PARITY: capture the parity bit -> STOP.
REQ-017 STOP, parity OK (odd over 8 data bits plus parity bit) and stop bit 1: keycode <= {keycode[7:0], byte} and oflag=1, both in the cycle after the stop-bit falling edge -> IDLE.
REQ-018 STOP, parity bad: parity_err=1 for one cycle, keycode unchanged, no oflag -> IDLE; parity check takes precedence over the stop-bit check.
REQ-019 STOP, parity OK but stop bit 0: frame_err=1 for one cycle, keycode unchanged -> IDLE.
REQ-020 In SHIFT, PARITY or STOP, an idle counter SHALL clear on every falling edge and increment otherwise; at TIMEOUT_CYCLES: frame_err=1 for one cycle, keycode unchanged, bit counter cleared -> IDLE.
REQ-021 The idle counter SHALL saturate and SHALL be held at 0 in IDLE; timeout and falling edge in the same cycle: the falling edge wins.
REQ-022 oflag, parity_err and frame_err SHALL be mutually exclusive and never high for 2 consecutive cycles; keycode SHALL hold between updates.
REQ-023 Latency: oflag SHALL rise exactly 1 clk cycle after the cycle in which the stop-bit falling edge is detected.

Reset
REQ-024 rst=1 SHALL immediately force: keycode=16'h0000; oflag, parity_err and frame_err =0; FSM=IDLE; bit and idle counters =0.
REQ-025 rst=1 SHALL immediately set synchronizer flops and filtered lines to 1 (idle high) and clear debounce counters, so that release of reset produces no false edge.
REQ-026 Reset mid-frame SHALL discard the partial byte; the first complete frame after release SHALL decode normally.

Verification
REQ-027 DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=2000, bit period 100 clk; frame for 0x29 with correct parity -> single oflag pulse 1 cycle after the stop falling edge, keycode=16'h0029.
REQ-028 Frames F0 then 29 -> two oflag pulses; keycode 16'h00F0 after the first, 16'hF029 after the second.
REQ-029 Frame 0x1C with inverted parity bit -> one parity_err pulse, no oflag, keycode unchanged.
REQ-030 Frame 0x23 with stop bit 0 -> one frame_err pulse, no oflag; a following valid 0x4D -> keycode low byte 8'h4D.
REQ-031 Start bit plus 4 data bits, then idle for 2000+ cycles -> one frame_err pulse, FSM back to IDLE; the next valid 0x23 decodes.
REQ-032 2-cycle low glitch on ps2_clk -> no sample taken; rst asserted mid-frame -> all outputs 0 immediately, next valid 0x29 -> keycode=16'h0029.
